// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD controller: default operand width and FSM state encoding.
package gcd_pkg;

  localparam int GCD_NUM_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CALC    = 3'd2,
    ST_FOUND   = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_RESP    = 3'd5
  } gcd_state_e;

endpackage

// File: rtl/gcd_ctrl.sv
// Control FSM for a subtractive GCD datapath: captures operand pairs, sequences
// load/step/found, bounds the number of subtraction steps and returns the result.
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int NUM_WIDTH  = GCD_NUM_WIDTH,
  parameter int ITER_LIMIT = 2**NUM_WIDTH-1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_WIDTH-1:0] in_a,
  input  logic [NUM_WIDTH-1:0] in_b,
  output logic [NUM_WIDTH-1:0] dp_a,
  output logic [NUM_WIDTH-1:0] dp_b,
  output logic                 load,
  output logic                 step,
  output logic                 a_sub_b,
  output logic                 found,
  input  logic                 equal,
  input  logic                 a_gt_b,
  input  logic [NUM_WIDTH-1:0] dp_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_WIDTH-1:0] out_gcd,
  output logic                 out_err,
  output logic                 busy
);

  localparam logic [NUM_WIDTH-1:0] LIMIT_C = NUM_WIDTH'(ITER_LIMIT);
  localparam logic [NUM_WIDTH-1:0] ONE_C   = NUM_WIDTH'(1);

  gcd_state_e           state_r;
  logic [NUM_WIDTH-1:0] cnt_r;
  logic [NUM_WIDTH-1:0] dp_a_r;
  logic [NUM_WIDTH-1:0] dp_b_r;
  logic [NUM_WIDTH-1:0] out_gcd_r;
  logic                 out_err_r;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic                 load_r;
  logic                 found_r;
  logic                 busy_r;
  logic                 step_s;
  logic                 a_sub_b_s;
  logic                 zero_pair_s;

  // Step decision must see the flags of the current cycle, so it stays combinational.
  always_comb begin
    step_s      = 1'b0;
    a_sub_b_s   = 1'b0;
    zero_pair_s = (in_a == '0) || (in_b == '0);
    if ((state_r == ST_CALC) && !equal && (cnt_r < LIMIT_C)) begin
      step_s    = 1'b1;
      a_sub_b_s = a_gt_b;
    end else begin
      step_s    = 1'b0;
      a_sub_b_s = 1'b0;
    end
  end

  // Main sequencer: state, operand capture, iteration counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      dp_a_r      <= '0;
      dp_b_r      <= '0;
      out_gcd_r   <= '0;
      out_err_r   <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      load_r      <= 1'b0;
      found_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready_r) begin
            dp_a_r     <= in_a;
            dp_b_r     <= in_b;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            if (zero_pair_s) begin
              // The OR of the operands is the nonzero one, or zero when both are.
              out_gcd_r   <= in_a | in_b;
              out_err_r   <= (in_a == '0) && (in_b == '0);
              out_valid_r <= 1'b1;
              state_r     <= ST_RESP;
            end else begin
              load_r  <= 1'b1;
              state_r <= ST_LOAD;
            end
          end else begin
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
          end
        end
        ST_LOAD: begin
          load_r  <= 1'b0;
          cnt_r   <= '0;
          state_r <= ST_CALC;
        end
        ST_CALC: begin
          if (equal) begin
            found_r <= 1'b1;
            state_r <= ST_FOUND;
          end else if (cnt_r < LIMIT_C) begin
            cnt_r <= cnt_r + ONE_C;
          end else begin
            out_gcd_r   <= '0;
            out_err_r   <= 1'b1;
            out_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end
        end
        ST_FOUND: begin
          found_r <= 1'b0;
          state_r <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          out_gcd_r   <= dp_result;
          out_err_r   <= 1'b0;
          out_valid_r <= 1'b1;
          state_r     <= ST_RESP;
        end
        ST_RESP: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          load_r      <= 1'b0;
          found_r     <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign dp_a      = dp_a_r;
  assign dp_b      = dp_b_r;
  assign load      = load_r;
  assign step      = step_s;
  assign a_sub_b   = a_sub_b_s;
  assign found     = found_r;
  assign out_valid = out_valid_r;
  assign out_gcd   = out_gcd_r;
  assign out_err   = out_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Scoreboard bench for gcd_ctrl with a behavioural subtractive datapath and a
// Euclid-based reference model computing result, step count and latency.
module tb_gcd_ctrl;

  localparam int W   = 16;
  localparam int LIM = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b, dp_a, dp_b, dp_result, out_gcd;
  logic         load, step, a_sub_b, found, equal, a_gt_b;
  logic         out_valid, out_ready, out_err, busy;

  gcd_ctrl #(.NUM_WIDTH(W), .ITER_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .dp_a(dp_a), .dp_b(dp_b),
    .load(load), .step(step), .a_sub_b(a_sub_b), .found(found),
    .equal(equal), .a_gt_b(a_gt_b), .dp_result(dp_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd),
    .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: registers A, B and result.
  logic [W-1:0] m_a, m_b, m_res;
  always @(posedge clk) begin
    if (rst) begin
      m_a <= '0; m_b <= '0; m_res <= '0;
    end else begin
      if (load) begin
        m_a <= dp_a; m_b <= dp_b;
      end else if (step) begin
        if (a_sub_b) m_a <= m_a - m_b;
        else         m_b <= m_b - m_a;
      end
      if (found) m_res <= m_a;
    end
  end
  assign equal     = (m_a == m_b);
  assign a_gt_b    = (m_a > m_b);
  assign dp_result = m_res;

  typedef struct {
    logic [W-1:0] gcd;
    logic         err;
    int           steps;
    int           loads;
    int           founds;
    int           lat;
    int           t_acc;
  } exp_t;

  exp_t exp_q[$];
  int   hold_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input longint act, input longint expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  // Euclid by division; subtractive steps = sum of quotients minus one.
  function automatic exp_t predict(input int unsigned a, input int unsigned b, input int t);
    exp_t e;
    int unsigned x, y, r;
    int k;
    e.t_acc = t;
    if (a == 0 || b == 0) begin
      e.gcd = (a == 0) ? W'(b) : W'(a);
      e.err = (a == 0 && b == 0);
      e.steps = 0; e.loads = 0; e.founds = 0; e.lat = 1;
    end else begin
      x = a; y = b; k = 0;
      while (y != 0) begin
        k += int'(x / y);
        r = x % y; x = y; y = r;
      end
      k -= 1;
      e.loads = 1;
      if (k <= LIM) begin
        e.gcd = W'(x); e.err = 1'b0; e.steps = k; e.founds = 1; e.lat = 5 + k;
      end else begin
        e.gcd = '0; e.err = 1'b1; e.steps = LIM; e.founds = 0; e.lat = 3 + LIM;
      end
    end
    return e;
  endfunction

  // Result-side ready: held low for a per-transaction number of cycles.
  initial begin
    int cnt, cur_hold;
    bit active;
    out_ready = 1'b0; active = 0; cnt = 0; cur_hold = 0;
    forever begin
      @(posedge clk); #1;
      if (rst || !out_valid) begin
        active = 0; out_ready = 1'b0;
      end else begin
        if (!active) begin
          active = 1; cnt = 0;
          cur_hold = (hold_q.size() > 0) ? hold_q.pop_front() : 0;
        end
        out_ready = (cnt >= cur_hold);
        cnt++;
      end
    end
  end

  bit           in_resp = 0;
  bit           post_hs = 0;
  bit           hold_ok, excl_ok;
  int           ld_cnt, st_cnt, fd_cnt;
  logic [W-1:0] hold_gcd;
  logic         hold_err;
  exp_t         cur;

  // Monitor: pops expectations whenever a response appears.
  initial begin
    hold_ok = 1; excl_ok = 1; ld_cnt = 0; st_cnt = 0; fd_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_resp = 0; post_hs = 0; hold_ok = 1; excl_ok = 1;
        ld_cnt = 0; st_cnt = 0; fd_cnt = 0;
      end else begin
        if (post_hs) begin
          chk("idle_after_handshake", {in_ready, busy, out_valid}, 3'b100);
          post_hs = 0;
        end
        if (load) ld_cnt++;
        if (step) st_cnt++;
        if (found) fd_cnt++;
        if ((int'(load) + int'(step) + int'(found)) > 1) excl_ok = 0;
        if (busy && in_ready) excl_ok = 0;
        if (out_valid && !in_resp) begin
          in_resp = 1; hold_ok = 1;
          hold_gcd = out_gcd; hold_err = out_err;
          if (exp_q.size() == 0) begin
            chk("spurious_out_valid", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            chk("latency", cyc - cur.t_acc, cur.lat);
            chk("out_gcd", out_gcd, cur.gcd);
            chk("out_err", out_err, cur.err);
            chk("step_count", st_cnt, cur.steps);
            chk("load_count", ld_cnt, cur.loads);
            chk("found_count", fd_cnt, cur.founds);
            chk("ctrl_exclusive", excl_ok, 1);
            chk("busy_in_resp", busy, 1);
          end
        end
        if (in_resp) begin
          if (out_gcd !== hold_gcd || out_err !== hold_err || in_ready !== 1'b0) hold_ok = 0;
          if (out_ready) begin
            chk("resp_stable", hold_ok, 1);
            in_resp = 0; post_hs = 1; excl_ok = 1;
            ld_cnt = 0; st_cnt = 0; fd_cnt = 0;
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl_outputs", {out_valid, load, step, found, busy, in_ready}, 6'b0);
    chk("rst_dp_a", dp_a, 0);
    chk("rst_dp_b", dp_b, 0);
    chk("rst_out_gcd", out_gcd, 0);
    chk("rst_out_err", out_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, input bit expect_resp);
    int w;
    bit ok;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_valid = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      w++;
    end while (!ok && w < 300);
    if (!ok) chk("in_ready_timeout", 0, 1);
    else if (expect_resp) begin
      hold_q.push_back(hold);
      exp_q.push_back(predict(a, b, cyc));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return '0;
    if (r == 9) return W'($urandom);
    return W'($urandom_range(1, 15));
  endfunction

  initial begin
    int w;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    do_reset();
    issue(16'd12, 16'd8, 0, 1);
    issue(16'd0, 16'd9, 0, 1);
    issue(16'd0, 16'd0, 0, 1);
    issue(16'd10, 16'd1, 0, 1);
    issue(16'd7, 16'd7, 5, 1);
    issue(16'd100, 16'd3, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    issue(16'd6, 16'd4, 1, 1);
    for (int i = 0; i < 40; i++) begin
      issue(pick(), pick(), int'($urandom_range(0, 3)), 1);
    end
    w = 0;
    while ((exp_q.size() != 0 || in_resp) && w < 2000) begin
      @(posedge clk);
      w++;
    end
    if (exp_q.size() != 0 || in_resp) chk("drain_timeout", 0, 1);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gcd_ctrl.md
GCD_CTRL -- requirements
Module: gcd_ctrl

Interface
REQ-001 SHALL have parameter NUM_WIDTH, default 16, meaning operand/result width in bits.
REQ-002 SHALL have parameter ITER_LIMIT, default 2**NUM_WIDTH-1, meaning maximum subtraction steps before abort.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ports in_valid in 1 / in_ready out 1, the operand-pair handshake.
REQ-006 SHALL have ports in_a, in_b  in  NUM_WIDTH  operands.
REQ-007 SHALL have ports dp_a, dp_b  out  NUM_WIDTH  captured operands presented to the datapath.
REQ-008 SHALL have port load  out  1  datapath loads dp_a/dp_b this cycle.
REQ-009 SHALL have port step  out  1  datapath performs one subtraction this cycle.
REQ-010 SHALL have port a_sub_b  out  1  1 = A-B, 0 = B-A; meaningful only with step.
REQ-011 SHALL have port found  out  1  datapath registers its result this cycle.
REQ-012 SHALL have ports equal, a_gt_b  in  1  datapath compare flags (A==B, A>B).
REQ-013 SHALL have port dp_result  in  NUM_WIDTH  datapath result register.
REQ-014 SHALL have ports out_valid out 1 / out_ready in 1, the result handshake.
REQ-015 SHALL have ports out_gcd out NUM_WIDTH / out_err out 1, the result and error flag.
REQ-016 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, CALC, FOUND, CAPTURE, RESP.
REQ-018 IDLE: in_ready=1. On in_valid, capture in_a/in_b into dp_a/dp_b, then go to LOAD, or to RESP if either operand is zero.
REQ-019 Zero operands: exactly one zero gives out_gcd = the nonzero operand, out_err=0; both zero give out_gcd=0, out_err=1.
REQ-020 LOAD: load=1 for exactly one cycle, clear the iteration counter, go to CALC.
REQ-021 CALC with equal=1: no step; go to FOUND.
REQ-022 CALC with equal=0 and counter<ITER_LIMIT: step=1, a_sub_b=a_gt_b (combinational), increment counter, stay in CALC.
REQ-023 CALC with equal=0 and counter==ITER_LIMIT: no step; out_gcd=0, out_err=1; go to RESP.
REQ-024 Flags SHALL be sampled assuming a step issued at cycle t is visible at t+1.
REQ-025 FOUND: found=1 for exactly one cycle, go to CAPTURE.
REQ-026 CAPTURE: register out_gcd<=dp_result and out_err<=0, go to RESP.
REQ-027 RESP: out_valid=1; out_gcd/out_err stable while out_ready=0; on out_ready go to IDLE.
REQ-028 in_ready SHALL be 0 outside IDLE. No bypass: a new pair is accepted no earlier than the cycle after the RESP handshake.
REQ-029 Latency SHALL be out_valid at T+5+k for a nonzero pair accepted at T with k steps, and T+1 for a zero-operand pair.
REQ-030 load, step and found SHALL be mutually exclusive and 0 outside LOAD, CALC and FOUND respectively.
REQ-031 The counter SHALL be NUM_WIDTH bits wide and SHALL NOT wrap (saturates by REQ-023).

Reset
REQ-032 On rst=1 at a clock edge, the block SHALL enter IDLE and zero the counter, dp_a, dp_b, out_gcd and out_err.
REQ-033 During reset, out_valid, load, step, found and busy SHALL be 0 and in_ready SHALL be 0.
REQ-034 Reset mid-operation SHALL discard the pending pair with no out_valid; in_ready=1 the cycle after rst deasserts.

Structure
REQ-035 Shared package gcd_pkg SHALL hold the FSM state enum and the default NUM_WIDTH constant.
REQ-036 No sub-module: FSM, operand capture and counter SHALL be inline in gcd_ctrl.

Verification
REQ-037 (12,8) accepted at T -> steps a_sub_b=1 then 0 (k=2); out_valid at T+7; out_gcd=4; out_err=0.
REQ-038 (0,9) -> out_valid at T+1, out_gcd=9, out_err=0; (0,0) -> out_gcd=0, out_err=1; load never asserted.
REQ-039 ITER_LIMIT=3, (10,1) -> exactly 3 steps, then out_valid, out_gcd=0, out_err=1.
REQ-040 (7,7) with out_ready held 0 for 5 cycles -> out_gcd=7 stable, in_ready=0 throughout; IDLE one cycle after out_ready.
REQ-041 rst pulsed during CALC of (100,3) -> no out_valid; a following (6,4) completes with out_gcd=2.
